mpmc10_wdf_stage: RTL and testbench
===================================

MPMC10_WDF_STAGE -- requirements
Module: mpmc10_wdf_stage

Interface
REQ-001 SHALL have parameter WID, default 16, meaning byte-lane count; data width is 8*WID.
REQ-002 SHALL have parameter TMO, default 255, meaning the ready-wait timeout in cycles, range 1..255.
REQ-003 SHALL have one clock and a synchronous active-low reset, listed first:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
REQ-004 SHALL have the remaining ports:
- start  input  1  single-cycle request from the controller, asserted on the cycle after mask is valid
- we  input  1  write request (1) or read request (0)
- mask  input  WID  byte mask from the write-mask stage; 1 = byte not written
- dat  input  8*WID  write data
- app_wdf_rdy  input  1  MIG write-data-FIFO ready
- app_wdf_data  output  8*WID  data to MIG
- app_wdf_mask  output  WID  mask to MIG
- app_wdf_wren  output  1  write-data valid to MIG
- app_wdf_end  output  1  last beat of burst to MIG
- busy  output  1  stage occupied (state != IDLE)
- done  output  1  single-cycle completion pulse
- err  output  1  timeout flag

Function
REQ-005 SHALL implement the states IDLE, WRITE and DONE.
REQ-006 In IDLE with start=1 and we=1, the block SHALL capture dat and mask into app_wdf_data/app_wdf_mask at the clock edge, go to WRITE, and assert app_wdf_wren=1 and app_wdf_end=1 from the next cycle.
REQ-007 In IDLE with start=1 and we=0, the block SHALL go to DONE without asserting app_wdf_wren; app_wdf_data and app_wdf_mask SHALL hold their previous values.
REQ-008 In WRITE, app_wdf_wren, app_wdf_end, app_wdf_data and app_wdf_mask SHALL be held stable until a cycle with app_wdf_rdy=1.
REQ-009 A cycle in WRITE with app_wdf_rdy=1 SHALL complete the beat; at that edge wren and end SHALL clear and the state SHALL go to DONE.
REQ-010 With app_wdf_rdy already high, a write SHALL take exactly one wren cycle: start at edge N, wren high N+1..N+2, done high N+2..N+3.
REQ-011 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-012 start SHALL be ignored when the state is not IDLE; no queuing.
REQ-013 busy SHALL be 1 in WRITE and DONE, and 0 in IDLE.
REQ-014 app_wdf_end SHALL always equal app_wdf_wren (one beat per burst).
REQ-015 we, mask and dat SHALL be sampled only on an accepted start; later changes SHALL not affect the beat in flight.

Reset
REQ-016 When rst_n=0 at a clock edge, the block SHALL enter IDLE and clear app_wdf_wren, app_wdf_end, done, err, the timeout counter, app_wdf_data and app_wdf_mask.
REQ-017 Reset SHALL override every other input, including start, and SHALL abort a write held in WRITE without asserting done.
REQ-018 The block SHALL not react to rst_n between clock edges.

Configuration
REQ-019 Macro MPMC10_WDF_TIMEOUT_EN SHALL select the ready-wait timeout.
REQ-020 With the macro defined:
- an 8-bit counter SHALL clear on entry to WRITE and increment each WRITE cycle with app_wdf_rdy=0
- when the counter equals TMO, the next edge SHALL clear wren/end, set err=1 and go to DONE
- err SHALL stay set until the next accepted start or reset
- app_wdf_rdy=1 in the same cycle the counter equals TMO SHALL count as a normal completion with no err
REQ-021 Without the macro, no counter SHALL exist, err SHALL be constant 0, and WRITE SHALL wait indefinitely.

Verification
REQ-022 The bench SHALL cover: rdy=1, start, we=1, dat=128'h0123..EF, mask=16'h00F0 -> wren/end high for 1 cycle with that data/mask, done 1 cycle later, busy 2 cycles.
REQ-023 The bench SHALL cover: rdy=0 for 5 cycles then 1 -> wren held 6 cycles with stable data; done on the 7th cycle after start.
REQ-024 The bench SHALL cover: start with we=0 -> no wren; done on the next cycle; app_wdf_mask unchanged.
REQ-025 The bench SHALL cover: start pulsed again while in WRITE with different dat -> ignored; original data completes; single done.
REQ-026 The bench SHALL cover: rst_n=0 during WRITE -> next edge wren=0, busy=0, done never pulses; a subsequent start works normally.
REQ-027 The bench SHALL cover, with MPMC10_WDF_TIMEOUT_EN and TMO=4: rdy held 0 -> wren drops after 5 WRITE cycles, err=1, done pulses; the next start clears err.

Source files
------------

// File: rtl/mpmc10_wdf_stage.sv
//------------------------------------------------------------------------------
// mpmc10_wdf_stage : single-beat write-data stage feeding the MIG write FIFO.
// Optional ready-wait timeout selected by macro MPMC10_WDF_TIMEOUT_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mpmc10_wdf_stage #(
    parameter int WID = 16,
    parameter int TMO = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               we,
    input  logic [WID-1:0]     mask,
    input  logic [8*WID-1:0]   dat,
    input  logic               app_wdf_rdy,
    output logic [8*WID-1:0]   app_wdf_data,
    output logic [WID-1:0]     app_wdf_mask,
    output logic               app_wdf_wren,
    output logic               app_wdf_end,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               w_accept;
    logic               w_timeout;
    logic [8*WID-1:0]   r_data;
    logic [WID-1:0]     r_mask;

    assign w_accept = (r_state == S_IDLE) && start;

`ifdef MPMC10_WDF_TIMEOUT_EN
    localparam logic [7:0] C_TMO = 8'(TMO);

    logic [7:0] r_cnt;
    logic       r_err;

    // A ready in the same cycle as the limit wins over the timeout.
    assign w_timeout = (r_state == S_WRITE) && !app_wdf_rdy && (r_cnt == C_TMO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (w_accept && we) begin
            r_cnt <= 8'd0;
        end else if ((r_state == S_WRITE) && !app_wdf_rdy && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = we ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                if (app_wdf_rdy || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        app_wdf_wren = (r_state == S_WRITE);
        app_wdf_end  = (r_state == S_WRITE);
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
    end

    // Data and mask are captured only on an accepted write; reads leave them untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_mask <= '0;
        end else if (w_accept && we) begin
            r_data <= dat;
            r_mask <= mask;
        end
    end

    assign app_wdf_data = r_data;
    assign app_wdf_mask = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_mpmc10_wdf_stage.sv
//------------------------------------------------------------------------------
// tb_mpmc10_wdf_stage : scoreboard bench for mpmc10_wdf_stage.
// Timeout scenario is exercised when MPMC10_WDF_TIMEOUT_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mpmc10_wdf_stage;

    localparam int WID = 16;
    localparam int DW  = 8*WID;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            we;
    logic [WID-1:0]  mask;
    logic [DW-1:0]   dat;
    logic            app_wdf_rdy;
    logic [DW-1:0]   app_wdf_data;
    logic [WID-1:0]  app_wdf_mask;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic            busy;
    logic            done;
    logic            err;

    mpmc10_wdf_stage #(.WID(WID), .TMO(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .we           (we),
        .mask         (mask),
        .dat          (dat),
        .app_wdf_rdy  (app_wdf_rdy),
        .app_wdf_data (app_wdf_data),
        .app_wdf_mask (app_wdf_mask),
        .app_wdf_wren (app_wdf_wren),
        .app_wdf_end  (app_wdf_end),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]  d;
        logic [WID-1:0] m;
    } beat_t;

    beat_t bq[$];
    bit    dq[$];
    int    checks = 0;
    int    errors = 0;
    logic  prev_wren = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [DW-1:0] d, input logic [WID-1:0] m);
        start = 1'b1;
        we    = w;
        dat   = d;
        mask  = m;
        tick();
        start = 1'b0;
        we    = ~w;
        dat   = ~d;
        mask  = ~m;
    endtask

    // Monitor: beats are compared against the queue head while wren is high
    // and retired when wren falls; each done pulse retires one expected err.
    always @(negedge clk) begin
        chk("end_eq_wren", DW'(app_wdf_end), DW'(app_wdf_wren));
        if (app_wdf_wren === 1'b1) begin
            if (bq.size() == 0) begin
                chk("unexpected_wren", 1, 0);
            end else begin
                chk("beat_data", app_wdf_data, bq[0].d);
                chk("beat_mask", DW'(app_wdf_mask), DW'(bq[0].m));
            end
        end
        if (prev_wren && (app_wdf_wren !== 1'b1) && (bq.size() > 0)) begin
            void'(bq.pop_front());
        end
        prev_wren = (app_wdf_wren === 1'b1);
        if (done === 1'b1) begin
            if (dq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("done_err", DW'(err), DW'(dq[0]));
                void'(dq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b1;
        we    = 1'b1;
        dat   = {DW{1'b1}};
        mask  = '1;
        app_wdf_rdy = 1'b1;
        tick(); tick(); tick();
        chk("rst_wren", DW'(app_wdf_wren), 0);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_done", DW'(done), 0);
        chk("rst_err",  DW'(err), 0);
        chk("rst_data", app_wdf_data, 0);
        chk("rst_mask", DW'(app_wdf_mask), 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        // Single write with ready already high.
        bq.push_back('{d: 128'h0123456789ABCDEF0123456789ABCDEF, m: 16'h00F0});
        dq.push_back(1'b0);
        issue(1'b1, 128'h0123456789ABCDEF0123456789ABCDEF, 16'h00F0);
        chk("t1_wren", DW'(app_wdf_wren), 1);
        chk("t1_busy_a", DW'(busy), 1);
        chk("t1_done_a", DW'(done), 0);
        tick();
        chk("t1_wren_off", DW'(app_wdf_wren), 0);
        chk("t1_done", DW'(done), 1);
        chk("t1_busy_b", DW'(busy), 1);
        tick();
        chk("t1_idle_busy", DW'(busy), 0);
        chk("t1_idle_done", DW'(done), 0);

        // Ready low for five cycles, then high.
        app_wdf_rdy = 1'b0;
        bq.push_back('{d: 128'hDEADBEEF_CAFEF00D_11223344_55667788, m: 16'h0F0F});
        dq.push_back(1'b0);
        issue(1'b1, 128'hDEADBEEF_CAFEF00D_11223344_55667788, 16'h0F0F);
        for (int i = 0; i < 5; i++) begin
            chk("t2_wren_hold", DW'(app_wdf_wren), 1);
            tick();
        end
        app_wdf_rdy = 1'b1;
        chk("t2_wren_last", DW'(app_wdf_wren), 1);
        tick();
        chk("t2_done", DW'(done), 1);
        tick();

        // Read request: no beat, done next cycle, mask untouched.
        dq.push_back(1'b0);
        issue(1'b0, 128'h5555, 16'hFFFF);
        chk("t3_wren", DW'(app_wdf_wren), 0);
        chk("t3_done", DW'(done), 1);
        chk("t3_mask", DW'(app_wdf_mask), DW'(16'h0F0F));
        chk("t3_data", app_wdf_data, 128'hDEADBEEF_CAFEF00D_11223344_55667788);
        tick();

        // Second start while in WRITE is ignored.
        app_wdf_rdy = 1'b0;
        bq.push_back('{d: 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, m: 16'h8001});
        dq.push_back(1'b0);
        issue(1'b1, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 16'h8001);
        issue(1'b1, 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, 16'h7FFE);
        app_wdf_rdy = 1'b1;
        chk("t4_wren", DW'(app_wdf_wren), 1);
        tick();
        chk("t4_done", DW'(done), 1);
        tick();
        chk("t4_idle", DW'(busy), 0);
        tick(); tick();

        // Reset during WRITE aborts without done.
        app_wdf_rdy = 1'b0;
        bq.push_back('{d: 128'h1234_5678, m: 16'h0003});
        issue(1'b1, 128'h1234_5678, 16'h0003);
        tick();
        rst_n = 1'b0;
        tick();
        chk("t5_wren", DW'(app_wdf_wren), 0);
        chk("t5_busy", DW'(busy), 0);
        chk("t5_done", DW'(done), 0);
        rst_n = 1'b1;
        app_wdf_rdy = 1'b1;
        tick();
        bq.push_back('{d: 128'h9876_5432_10FE_DCBA, m: 16'hC000});
        dq.push_back(1'b0);
        issue(1'b1, 128'h9876_5432_10FE_DCBA, 16'hC000);
        chk("t5_rewrite", DW'(app_wdf_wren), 1);
        tick();
        chk("t5_redone", DW'(done), 1);
        tick();

`ifdef MPMC10_WDF_TIMEOUT_EN
        // Ready never arrives: five WRITE cycles with TMO=4, then err.
        app_wdf_rdy = 1'b0;
        bq.push_back('{d: 128'h0BAD_F00D, m: 16'h00FF});
        dq.push_back(1'b1);
        issue(1'b1, 128'h0BAD_F00D, 16'h00FF);
        n = 0;
        while ((app_wdf_wren === 1'b1) && (n < 20)) begin
            n++;
            tick();
        end
        chk("t6_wren_cycles", DW'(n), 5);
        chk("t6_done", DW'(done), 1);
        chk("t6_err", DW'(err), 1);
        tick();
        chk("t6_err_hold", DW'(err), 1);
        dq.push_back(1'b0);
        issue(1'b0, '0, '0);
        chk("t6_err_clear", DW'(err), 0);
        tick();
`else
        app_wdf_rdy = 1'b0;
        bq.push_back('{d: 128'h0BAD_F00D, m: 16'h00FF});
        issue(1'b1, 128'h0BAD_F00D, 16'h00FF);
        n = 0;
        while ((app_wdf_wren === 1'b1) && (n < 300)) begin
            n++;
            tick();
        end
        chk("t6_no_timeout", DW'(n), 300);
        chk("t6_err_zero", DW'(err), 0);
        dq.push_back(1'b0);
        app_wdf_rdy = 1'b1;
        tick();
        tick();
`endif
        tick(); tick();
        chk("bq_empty", DW'(bq.size()), 0);
        chk("dq_empty", DW'(dq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
